// File: rtl/kyber_keygen_seq_if.sv
// rtl/kyber_keygen_seq_if.sv - start/busy/done handshake and key buses of the Baby-Kyber keygen core
// Requester drives start and A/s/e; the core returns status, t and the registered key material.
interface kyber_keygen_seq_if #(
    parameter int K  = 2,
    parameter int N  = 4,
    parameter int CW = 16
);
    logic                  start;
    logic [K*K*N*CW-1:0]   a_in;
    logic [K*N*CW-1:0]     s_in;
    logic [K*N*CW-1:0]     e_in;
    logic                  busy;
    logic                  done;
    logic                  t_valid;
    logic [K*N*CW-1:0]     t_out;
    logic [K*K*N*CW-1:0]   a_out;
    logic [K*N*CW-1:0]     s_out;

    modport master (
        output start, a_in, s_in, e_in,
        input  busy, done, t_valid, t_out, a_out, s_out
    );

    modport slave (
        input  start, a_in, s_in, e_in,
        output busy, done, t_valid, t_out, a_out, s_out
    );
endinterface

// File: rtl/kyber_keygen_seq.sv
// rtl/kyber_keygen_seq.sv - sequential Baby-Kyber keygen t = A*s + e, one MAC term per cycle
// KEYGEN_CENTERED_OUT_EN: when defined, t_out holds centered values instead of canonical [0,Q).
module kyber_keygen_seq #(
    parameter int K  = 2,
    parameter int N  = 4,
    parameter int Q  = 17,
    parameter int CW = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    kyber_keygen_seq_if.slave  bus
);
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int NW = $clog2(N);
    localparam int AW = 2*CW + $clog2(K*N) + 1;
    localparam logic signed [AW-1:0] QS   = AW'(Q);
    localparam logic signed [AW-1:0] HALF = AW'((Q-1)/2);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_RED, S_DONE} state_e;

    state_e state_q, state_d;

    logic [KW-1:0]          i_q, j_q, ni;
    logic [NW-1:0]          m_q, n_q, nm, sidx;
    logic signed [AW-1:0]   acc_q;
    logic signed [CW-1:0]   a_q [K][K][N];
    logic signed [CW-1:0]   s_q [K][N];
    logic signed [CW-1:0]   e_q [K][N];
    logic signed [CW-1:0]   t_q [K][N];
    logic [K*N*CW-1:0]      t_out_q;
    logic                   t_valid_q;

    logic                   accept, last_term, last_coef;
    logic signed [CW-1:0]   a_sel, s_sel, r;
    logic signed [2*CW-1:0] prod;
    logic signed [AW-1:0]   prod_ext, term, rem, rpos, rc;

    assign last_term = (j_q == KW'(K-1)) && (n_q == NW'(N-1));
    assign last_coef = (i_q == KW'(K-1)) && (m_q == NW'(N-1));

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC:   if (last_term) state_d = S_RED;
            S_RED:   state_d = last_coef ? S_DONE : S_MAC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Negacyclic term: x^N = -1, so indices that wrap (n > m) subtract.
    always_comb begin
        sidx     = m_q - n_q;
        a_sel    = a_q[i_q][j_q][n_q];
        s_sel    = s_q[j_q][sidx];
        prod     = a_sel * s_sel;
        prod_ext = AW'(prod);
        term     = (n_q > m_q) ? -prod_ext : prod_ext;
        rem      = acc_q % QS;
        rpos     = (rem < 0) ? rem + QS : rem;
`ifdef KEYGEN_CENTERED_OUT_EN
        rc       = (rpos > HALF) ? rpos - QS : rpos;
`else
        rc       = rpos;
`endif
        r        = CW'(rc);
        ni       = i_q;
        nm       = m_q + 1'b1;
        if (m_q == NW'(N-1)) begin
            nm = '0;
            ni = last_coef ? '0 : i_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q       <= '0;
            j_q       <= '0;
            m_q       <= '0;
            n_q       <= '0;
            acc_q     <= '0;
            t_out_q   <= '0;
            t_valid_q <= 1'b0;
            for (int x = 0; x < K; x++) begin
                for (int y = 0; y < N; y++) begin
                    s_q[x][y] <= '0;
                    e_q[x][y] <= '0;
                    t_q[x][y] <= '0;
                    for (int z = 0; z < K; z++) a_q[x][z][y] <= '0;
                end
            end
        end else begin
            if (accept) begin
                for (int x = 0; x < K; x++) begin
                    for (int y = 0; y < N; y++) begin
                        s_q[x][y] <= bus.s_in[(x*N+y)*CW +: CW];
                        e_q[x][y] <= bus.e_in[(x*N+y)*CW +: CW];
                        for (int z = 0; z < K; z++)
                            a_q[x][z][y] <= bus.a_in[((x*K+z)*N+y)*CW +: CW];
                    end
                end
                t_valid_q <= 1'b0;
                i_q       <= '0;
                j_q       <= '0;
                m_q       <= '0;
                n_q       <= '0;
                acc_q     <= AW'($signed(bus.e_in[CW-1:0]));
            end else if (state_q == S_MAC) begin
                acc_q <= acc_q + term;
                if (n_q == NW'(N-1)) begin
                    n_q <= '0;
                    j_q <= last_term ? '0 : j_q + 1'b1;
                end else begin
                    n_q <= n_q + 1'b1;
                end
            end else if (state_q == S_RED) begin
                t_q[i_q][m_q] <= r;
                i_q   <= ni;
                m_q   <= nm;
                j_q   <= '0;
                n_q   <= '0;
                acc_q <= AW'(e_q[ni][nm]);
                // Publish all coefficients together, folding in the one reduced this cycle.
                if (last_coef) begin
                    t_valid_q <= 1'b1;
                    for (int x = 0; x < K; x++)
                        for (int y = 0; y < N; y++)
                            t_out_q[(x*N+y)*CW +: CW] <=
                                (x == int'(i_q) && y == int'(m_q)) ? r : t_q[x][y];
                end
            end
        end
    end

    for (genvar gi = 0; gi < K; gi++) begin : g_out_i
        for (genvar gn = 0; gn < N; gn++) begin : g_out_n
            assign bus.s_out[(gi*N+gn)*CW +: CW] = s_q[gi][gn];
            for (genvar gj = 0; gj < K; gj++) begin : g_out_j
                assign bus.a_out[((gi*K+gj)*N+gn)*CW +: CW] = a_q[gi][gj][gn];
            end
        end
    end

    assign bus.t_out   = t_out_q;
    assign bus.t_valid = t_valid_q;
    assign bus.busy    = (state_q == S_MAC) || (state_q == S_RED);
    assign bus.done    = (state_q == S_DONE);
endmodule

// File: tb/tb_kyber_keygen_seq.sv
// tb/tb_kyber_keygen_seq.sv - self-checking bench for kyber_keygen_seq
// Polynomial-product model plus directed vectors with hand-computed results.
module tb_kyber_keygen_seq;
    localparam int K = 2, N = 4, Q = 17, CW = 16;
    localparam int A_W = K*K*N*CW, V_W = K*N*CW;

    logic clk = 1'b0;
    logic rst_n;

    kyber_keygen_seq_if #(.K(K), .N(N), .CW(CW)) bus ();
    kyber_keygen_seq #(.K(K), .N(N), .Q(Q), .CW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [A_W-1:0] act, input logic [A_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [V_W-1:0] pv(input int c[K*N]);
        logic [V_W-1:0] v;
        int t;
        v = '0;
        for (int x = 0; x < K*N; x++) begin
            t = c[x];
            v[x*CW +: CW] = t[CW-1:0];
        end
        return v;
    endfunction

    // t_i = sum_j a_ij * s_j + e_i in Z_Q[x]/(x^N+1), reduced to the output range.
    function automatic logic [V_W-1:0] model_t(input logic [A_W-1:0] a, input logic [V_W-1:0] s,
                                               input logic [V_W-1:0] e);
        logic [V_W-1:0] res;
        logic signed [CW-1:0] ca, cs, ce;
        longint acc, r;
        res = '0;
        for (int i = 0; i < K; i++) begin
            for (int m = 0; m < N; m++) begin
                ce  = e[(i*N+m)*CW +: CW];
                acc = longint'(ce);
                for (int j = 0; j < K; j++)
                    for (int n = 0; n < N; n++)
                        for (int k = 0; k < N; k++)
                            if ((n + k) % N == m) begin
                                ca = a[((i*K+j)*N+n)*CW +: CW];
                                cs = s[(j*N+k)*CW +: CW];
                                if (n + k >= N) acc -= longint'(ca) * longint'(cs);
                                else            acc += longint'(ca) * longint'(cs);
                            end
                r = acc % Q;
                if (r < 0) r += Q;
`ifdef KEYGEN_CENTERED_OUT_EN
                if (r > (Q-1)/2) r -= Q;
`endif
                res[(i*N+m)*CW +: CW] = r[CW-1:0];
            end
        end
        return res;
    endfunction

    logic             exp_busy = 0, exp_done = 0, exp_tv = 0;
    logic [V_W-1:0]   exp_t = '0, exp_s = '0, cap_s = '0, cap_e = '0;
    logic [A_W-1:0]   exp_a = '0, cap_a = '0;
    int               rem_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_busy = 0; exp_done = 0; exp_tv = 0;
            exp_t = '0; exp_s = '0; exp_a = '0; rem_cnt = 0;
        end else if (!exp_busy && !exp_done) begin
            if (bus.start) begin
                cap_a = bus.a_in; cap_s = bus.s_in; cap_e = bus.e_in;
                exp_a = bus.a_in; exp_s = bus.s_in;
                exp_tv = 0; exp_busy = 1;
                rem_cnt = K*N*(K*N+1);
            end
        end else if (exp_busy) begin
            rem_cnt--;
            if (rem_cnt == 0) begin
                exp_busy = 0; exp_done = 1; exp_tv = 1;
                exp_t = model_t(cap_a, cap_s, cap_e);
            end
        end else begin
            exp_done = 0;
        end
    end

    always @(negedge clk) begin
        chk("busy", A_W'(bus.busy), A_W'(exp_busy));
        chk("done", A_W'(bus.done), A_W'(exp_done));
        chk("t_valid", A_W'(bus.t_valid), A_W'(exp_tv));
        chk("t_out", A_W'(bus.t_out), A_W'(exp_t));
        chk("a_out", bus.a_out, exp_a);
        chk("s_out", A_W'(bus.s_out), A_W'(exp_s));
    end

    task automatic run_op(input logic [A_W-1:0] a, input logic [V_W-1:0] s, input logic [V_W-1:0] e,
                          input bit pulses, input int rst_at, output int lat);
        int cyc;
        cyc = 0;
        lat = -1;
        @(posedge clk); #1;
        bus.a_in = a; bus.s_in = s; bus.e_in = e; bus.start = 1'b1;
        while (cyc < 200) begin
            @(posedge clk); cyc++; #1;
            bus.start = 1'b0;
            if (cyc == 1) begin
                bus.a_in = {16{$urandom}}; bus.s_in = {4{$urandom}}; bus.e_in = {4{$urandom}};
            end
            if (pulses && cyc == 5) bus.start = 1'b1;
            if (cyc == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", A_W'(bus.busy), '0);
                chk("rst_done", A_W'(bus.done), '0);
                chk("rst_tvalid", A_W'(bus.t_valid), '0);
                chk("rst_t_out", A_W'(bus.t_out), '0);
                chk("rst_a_out", bus.a_out, '0);
                chk("rst_s_out", A_W'(bus.s_out), '0);
                break;
            end
            @(negedge clk);
            if (cyc == 1) chk("tvalid_cleared", A_W'(bus.t_valid), '0);
            if (bus.done) begin
                lat = cyc;
                break;
            end
        end
        if (pulses && lat > 0) begin
            bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
    endtask

    logic [A_W-1:0] a1, a2, a3, ar;
    logic [V_W-1:0] s1, e1, s2, e2, s3, e3, sr, er, lit1, lit2, lit3;
    int lat;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a_in = '0; bus.s_in = '0; bus.e_in = '0;

        a1 = '0;
        s1 = pv('{3, -2, 7, 0, 1, 1, -8, 5});
        e1 = pv('{1, 2, 3, 4, -1, 0, 16, 20});
        a2 = '0; a2[1*CW +: CW] = 16'd1;
        s2 = pv('{1, 2, 3, 4, 0, 0, 0, 0});
        e2 = '0;
        a3 = '0; a3[0 +: CW] = 16'hFFFF; a3[8*CW +: CW] = 16'd3;
        s3 = pv('{5, 0, 0, 0, 0, 0, 0, 0});
        e3 = '0;
`ifdef KEYGEN_CENTERED_OUT_EN
        lit1 = pv('{1, 2, 3, 4, -1, 0, -1, 3});
        lit2 = pv('{-4, 1, 2, 3, 0, 0, 0, 0});
        lit3 = pv('{-5, 0, 0, 0, -2, 0, 0, 0});
`else
        lit1 = pv('{1, 2, 3, 4, 16, 0, 16, 3});
        lit2 = pv('{13, 1, 2, 3, 0, 0, 0, 0});
        lit3 = pv('{12, 0, 0, 0, 15, 0, 0, 0});
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", A_W'(bus.busy), '0);
        chk("reset_t_valid", A_W'(bus.t_valid), '0);
        chk("reset_t_out", A_W'(bus.t_out), '0);
        rst_n = 1'b1;

        chk("model_pin_1", A_W'(model_t(a1, s1, e1)), A_W'(lit1));
        chk("model_pin_2", A_W'(model_t(a2, s2, e2)), A_W'(lit2));
        chk("model_pin_3", A_W'(model_t(a3, s3, e3)), A_W'(lit3));

        run_op(a1, s1, e1, 1'b0, -1, lat);
        chk("latency_defaults", A_W'(lat), A_W'(73));
        chk("t_defaults", A_W'(bus.t_out), A_W'(lit1));
        chk("s_out_defaults", A_W'(bus.s_out), A_W'(s1));
        chk("a_out_defaults", bus.a_out, '0);

        run_op(a2, s2, e2, 1'b0, -1, lat);
        chk("latency_wrap", A_W'(lat), A_W'(73));
        chk("t_wrap", A_W'(bus.t_out), A_W'(lit2));

        run_op(a3, s3, e3, 1'b0, -1, lat);
        chk("t_negative", A_W'(bus.t_out), A_W'(lit3));
        chk("a_out_negative", bus.a_out, a3);

        run_op(a2, s2, e2, 1'b1, -1, lat);
        chk("latency_handshake", A_W'(lat), A_W'(73));
        chk("t_handshake", A_W'(bus.t_out), A_W'(lit2));
        repeat (5) @(posedge clk);
        #1;
        chk("t_valid_held", A_W'(bus.t_valid), A_W'(1));
        chk("busy_idle", A_W'(bus.busy), '0);

        run_op(a1, s1, e1, 1'b0, 20, lat);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(a1, s1, e1, 1'b0, -1, lat);
        chk("latency_after_reset", A_W'(lat), A_W'(73));
        chk("t_after_reset", A_W'(bus.t_out), A_W'(lit1));

        for (int r = 0; r < 2; r++) begin
            ar = {16{$urandom}}; sr = {4{$urandom}}; er = {4{$urandom}};
            run_op(ar, sr, er, 1'b0, -1, lat);
            chk("latency_random", A_W'(lat), A_W'(73));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
